// File: rtl/punc_dbg_pkg.sv
// -----------------------------------------------------------------------------
// punc_dbg_pkg
// Shared types and constants for the PUnC debug-port scanner.
//   state_e  : scanner FSM states
//   TAG_*    : word-class codes carried on out_tag
//   NUM_RF   : number of PUnC general registers swept after the PC
// Optional build macro used by the scanner: PUNC_DBG_CHECKSUM_EN.
// -----------------------------------------------------------------------------
package punc_dbg_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    CAP  = 3'd2,
    SEND = 3'd3,
    FIN  = 3'd4
  } state_e;

  localparam logic [1:0] TAG_PC   = 2'd0;
  localparam logic [1:0] TAG_RF   = 2'd1;
  localparam logic [1:0] TAG_MEM  = 2'd2;
  localparam logic [1:0] TAG_CSUM = 2'd3;

  localparam int NUM_RF = 8;

endpackage

// File: rtl/punc_debug_scanner_if.sv
// -----------------------------------------------------------------------------
// punc_debug_scanner_if
// Valid/ready output stream of the debug scanner.
//   out_valid : word valid (master -> slave)
//   out_ready : sink ready (slave -> master)
//   out_data  : 16-bit sampled word
//   out_tag   : word class (PC / register / memory / checksum)
//   out_last  : final word of a scan
// -----------------------------------------------------------------------------
interface punc_debug_scanner_if;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_tag;
  logic        out_last;

  modport master (output out_valid, output out_data, output out_tag,
                  output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_tag,
                  input out_last, output out_ready);
endinterface

// File: rtl/punc_dbg_outreg.sv
// -----------------------------------------------------------------------------
// punc_dbg_outreg
// Single-entry valid/ready holding register for the scanner output stream.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_* and raise out_valid (only issued while empty)
//   load_data  : word to present
//   load_tag   : word class
//   load_last  : final-word marker
//   stream     : master side of the output stream
// Fields stay frozen while a word waits for out_ready.
// -----------------------------------------------------------------------------
import punc_dbg_pkg::*;

module punc_dbg_outreg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_data,
  input  logic [1:0]  load_tag,
  input  logic        load_last,
  punc_debug_scanner_if.master stream
);

  // Holding register: reset drops any held word, load fills, handshake empties
  always_ff @(posedge clk) begin
    if (rst) begin
      stream.out_valid <= 1'b0;
      stream.out_data  <= 16'h0000;
      stream.out_tag   <= TAG_PC;
      stream.out_last  <= 1'b0;
    end else if (load) begin
      stream.out_valid <= 1'b1;
      stream.out_data  <= load_data;
      stream.out_tag   <= load_tag;
      stream.out_last  <= load_last;
    end else if (stream.out_valid && stream.out_ready) begin
      stream.out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/punc_debug_scanner.sv
// -----------------------------------------------------------------------------
// punc_debug_scanner
// Reader-side master for the PUnC debug port. On an accepted start it sweeps
// PC, R0..R7 and a memory window [mem_base, mem_base+mem_count) and emits each
// sampled word on a valid/ready stream.
//   clk, rst      : clock, synchronous active-high reset
//   start         : begin a scan (honoured only in IDLE)
//   mem_base      : first memory address (latched on accepted start)
//   mem_count     : memory words to dump, 0 = none (latched on accepted start)
//   busy, done    : scan in progress / one-cycle completion pulse
//   dbg_mem_addr  : drives PUnC mem_debug_addr
//   dbg_rf_addr   : drives PUnC rf_debug_addr
//   dbg_*_data    : PUnC debug read data (mem / rf / pc)
//   stream        : output word stream (master)
// Build macro PUNC_DBG_CHECKSUM_EN appends a tag-3 word holding the 16-bit sum
// of all preceding words of the scan; only that word carries out_last.
// -----------------------------------------------------------------------------
import punc_dbg_pkg::*;

module punc_debug_scanner #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] mem_base,
  input  logic [CNT_W-1:0]  mem_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] dbg_mem_addr,
  output logic [2:0]        dbg_rf_addr,
  input  logic [15:0]       dbg_mem_data,
  input  logic [15:0]       dbg_rf_data,
  input  logic [15:0]       dbg_pc_data,
  punc_debug_scanner_if.master stream
);

  state_e             state_r, next_s;
  logic [ADDR_W-1:0]  base_r;
  logic [CNT_W-1:0]   count_r;
  logic [1:0]         kind_r;       // class of the current item (tag encoding)
  logic [2:0]         rf_idx_r;
  logic [CNT_W-1:0]   off_r;
  logic               busy_r, done_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [2:0]         rf_addr_r;

  logic               hs_s, accept_s, advance_s, load_s, is_last_s;
  logic [1:0]         nxt_kind_s;
  logic [2:0]         nxt_rf_s;
  logic [CNT_W-1:0]   nxt_off_s;
  logic [15:0]        cap_data_s;

`ifdef PUNC_DBG_CHECKSUM_EN
  logic [15:0]        sum_r;
`endif

  assign hs_s = stream.out_valid & stream.out_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // FSM next state and per-cycle strobes
  always_comb begin
    next_s    = state_r;
    accept_s  = 1'b0;
    advance_s = 1'b0;
    load_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          next_s   = ADDR;
        end else begin
          next_s   = IDLE;
        end
      end
      ADDR: next_s = CAP;
      CAP: begin
        load_s = 1'b1;
        next_s = SEND;
      end
      SEND: begin
        if (hs_s) begin
          if (stream.out_last) begin
            next_s = FIN;
          end else begin
            advance_s = 1'b1;
            next_s    = ADDR;
          end
        end else begin
          next_s = SEND;
        end
      end
      FIN:     next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Item sequencing: successor of the current item, final-item flag, sample mux
  always_comb begin
    nxt_kind_s = kind_r;
    nxt_rf_s   = rf_idx_r;
    nxt_off_s  = off_r;
    is_last_s  = 1'b0;
    cap_data_s = 16'h0000;
    case (kind_r)
      TAG_PC: begin
        nxt_kind_s = TAG_RF;
        nxt_rf_s   = 3'd0;
        cap_data_s = dbg_pc_data;
      end
      TAG_RF: begin
        cap_data_s = dbg_rf_data;
        if (rf_idx_r == 3'(NUM_RF - 1)) begin
          if (count_r != {CNT_W{1'b0}}) begin
            nxt_kind_s = TAG_MEM;
            nxt_off_s  = {CNT_W{1'b0}};
          end else begin
`ifdef PUNC_DBG_CHECKSUM_EN
            nxt_kind_s = TAG_CSUM;
`else
            is_last_s  = 1'b1;
`endif
          end
        end else begin
          nxt_rf_s = rf_idx_r + 3'd1;
        end
      end
      TAG_MEM: begin
        cap_data_s = dbg_mem_data;
        // count_r is non-zero whenever a memory item exists
        if (off_r != count_r - CNT_W'(1)) begin
          nxt_off_s = off_r + CNT_W'(1);
        end else begin
`ifdef PUNC_DBG_CHECKSUM_EN
          nxt_kind_s = TAG_CSUM;
`else
          is_last_s  = 1'b1;
`endif
        end
      end
      default: begin
`ifdef PUNC_DBG_CHECKSUM_EN
        cap_data_s = sum_r;
        is_last_s  = 1'b1;
`else
        cap_data_s = 16'h0000;
        is_last_s  = 1'b1;
`endif
      end
    endcase
  end

  // Scan context, debug addresses and status outputs. Addresses for the next
  // item are registered on the handshake that leaves SEND, so they are stable
  // through both ADDR and CAP before the sample at the end of CAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r     <= {ADDR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      kind_r     <= TAG_PC;
      rf_idx_r   <= 3'd0;
      off_r      <= {CNT_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
      rf_addr_r  <= 3'd0;
    end else begin
      done_r <= (state_r == SEND) && hs_s && stream.out_last;
      if (accept_s) begin
        base_r   <= mem_base;
        count_r  <= mem_count;
        busy_r   <= 1'b1;
        kind_r   <= TAG_PC;
        rf_idx_r <= 3'd0;
        off_r    <= {CNT_W{1'b0}};
      end
      if (advance_s) begin
        kind_r   <= nxt_kind_s;
        rf_idx_r <= nxt_rf_s;
        off_r    <= nxt_off_s;
        if (nxt_kind_s == TAG_RF) begin
          rf_addr_r <= nxt_rf_s;
        end
        if (nxt_kind_s == TAG_MEM) begin
          mem_addr_r <= base_r + ADDR_W'(nxt_off_s);
        end
      end
      if (state_r == FIN) begin
        busy_r <= 1'b0;
      end
    end
  end

`ifdef PUNC_DBG_CHECKSUM_EN
  // Running sum of emitted words, restarted by each accepted scan
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r <= 16'h0000;
    end else if (accept_s) begin
      sum_r <= 16'h0000;
    end else if (hs_s) begin
      sum_r <= sum_r + stream.out_data;
    end
  end
`endif

  assign busy         = busy_r;
  assign done         = done_r;
  assign dbg_mem_addr = mem_addr_r;
  assign dbg_rf_addr  = rf_addr_r;

  punc_dbg_outreg u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_data (cap_data_s),
    .load_tag  (kind_r),
    .load_last (is_last_s),
    .stream    (stream)
  );

endmodule

// File: tb/tb_punc_debug_scanner.sv
// -----------------------------------------------------------------------------
// tb_punc_debug_scanner
// Scoreboard bench: each scan pushes its expected word list (built from the
// PC / register / memory images) into a queue; a monitor pops and compares on
// every stream handshake and checks that stalled words stay frozen.
// -----------------------------------------------------------------------------
module tb_punc_debug_scanner;
  import punc_dbg_pkg::*;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  tag;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] mem_base = 16'h0000;
  logic [15:0] mem_count = 16'h0000;
  logic        busy, done;
  logic [15:0] dbg_mem_addr;
  logic [2:0]  dbg_rf_addr;
  logic [15:0] dbg_mem_data, dbg_rf_data, dbg_pc_data;

  logic [15:0] mem [0:65535];
  logic [15:0] rf  [0:7];
  logic [15:0] pc;

  word_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    rx_cnt = 0;
  int    done_cnt = 0;
  int    hold_lim = 32'h7fffffff;
  bit    ready_rand = 1'b0;

  punc_debug_scanner_if sif();

  punc_debug_scanner dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mem_base     (mem_base),
    .mem_count    (mem_count),
    .busy         (busy),
    .done         (done),
    .dbg_mem_addr (dbg_mem_addr),
    .dbg_rf_addr  (dbg_rf_addr),
    .dbg_mem_data (dbg_mem_data),
    .dbg_rf_data  (dbg_rf_data),
    .dbg_pc_data  (dbg_pc_data),
    .stream       (sif)
  );

  always #5 clk = ~clk;

  // PUnC debug port model: registered memory read, combinational rf/pc
  always @(posedge clk) dbg_mem_data <= mem[dbg_mem_addr];
  assign dbg_rf_data = rf[dbg_rf_addr];
  assign dbg_pc_data = pc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, expv);
    end
  endtask

  // Sink ready driver
  initial begin
    sif.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sif.out_ready = (rx_cnt < hold_lim) &&
                      (ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
    end
  end

  // Monitor: scoreboard pop on handshake, frozen-word check while stalled
  word_t cur_w, held_w, exp_w;
  bit    stalled = 1'b0;
  always @(negedge clk) begin
    cur_w = {sif.out_data, sif.out_tag, sif.out_last};
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        chk("stall_hold", {12'h000, sif.out_valid, cur_w}, {12'h000, 1'b1, held_w});
      if (done) done_cnt++;
      if (sif.out_valid && sif.out_ready) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: actual=%h required=none", cur_w);
        end else begin
          exp_w = exp_q.pop_front();
          chk("word", {13'h0000, cur_w}, {13'h0000, exp_w});
        end
      end
      stalled = sif.out_valid && !sif.out_ready;
      held_w  = cur_w;
    end
  end

  // Reference model: the ordered word list of one scan
  task automatic push_scan(input logic [15:0] base, input int cnt, output int total);
    word_t       w;
    logic [15:0] sum;
    sum   = 16'h0000;
    total = 9 + cnt;
`ifdef PUNC_DBG_CHECKSUM_EN
    total = total + 1;
`endif
    for (int idx = 0; idx < total; idx++) begin
      if (idx == 0)             w = {pc, TAG_PC, 1'b0};
      else if (idx <= 8)        w = {rf[idx-1], TAG_RF, 1'b0};
      else if (idx < 9 + cnt)   w = {mem[16'(base + idx - 9)], TAG_MEM, 1'b0};
      else                      w = {sum, TAG_CSUM, 1'b0};
      w.last = (idx == total - 1);
      sum = sum + w.data;
      exp_q.push_back(w);
    end
  endtask

  task automatic run_scan(input logic [15:0] base, input logic [15:0] cnt,
                          input int poke_busy, input bit poke_fin);
    int c, total, d0, r0;
    bit seen;
    push_scan(base, int'(cnt), total);
    d0 = done_cnt;
    r0 = rx_cnt;
    @(posedge clk); #1;
    mem_base = base; mem_count = cnt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mem_base = 16'($urandom); mem_count = 16'($urandom);
    c = 0;
    while (!sif.out_valid && c < 10) begin
      @(negedge clk);
      c++;
    end
    chk("first_valid_latency", c, 3);
    chk("busy_high", busy, 1'b1);
    c = 0; seen = 1'b0;
    while (!seen && c < 4000) begin
      @(negedge clk);
      c++;
      if (done) seen = 1'b1;
      else start = (poke_busy > 0) && (c == poke_busy);
    end
    chk("done_seen", seen, 1'b1);
    if (seen && poke_fin) begin
      start = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("busy_after", busy, 1'b0);
    chk("valid_after", sif.out_valid, 1'b0);
    chk("done_once", done_cnt - d0, 1);
    chk("word_count", rx_cnt - r0, total);
    chk("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic reset_mid_scan();
    int c, total, d0;
    push_scan(16'h4000, 3, total);
    ready_rand = 1'b1;
    hold_lim = rx_cnt + 4;
    @(posedge clk); #1;
    mem_base = 16'h4000; mem_count = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (!(sif.out_valid && !sif.out_ready && rx_cnt == hold_lim) && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("fifth_word_stalled", (c < 500), 1'b1);
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", sif.out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    exp_q.delete();
    hold_lim = 32'h7fffffff;
    repeat (15) @(negedge clk);
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_idle_valid", sif.out_valid, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
    pc = 16'($urandom);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", sif.out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_mem_addr", dbg_mem_addr, 16'h0000);
    chk("reset_rf_addr", dbg_rf_addr, 3'd0);
    chk("reset_last", sif.out_last, 1'b0);

    // Directed scan from the plan
    pc = 16'h3000;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0010 + 16'(i);
    mem[16'h3000] = 16'hABCD;
    mem[16'h3001] = 16'h1234;
    ready_rand = 1'b0;
    run_scan(16'h3000, 16'd2, 0, 1'b0);
    ready_rand = 1'b1;
    run_scan(16'h3000, 16'd2, 0, 1'b0);

    // No memory window
    ready_rand = 1'b0;
    run_scan(16'h1234, 16'd0, 0, 1'b0);
    ready_rand = 1'b1;
    run_scan(16'h0000, 16'd0, 0, 1'b0);

    // Address wrap
    mem[16'hFFFF] = 16'h0F0F;
    mem[16'h0000] = 16'h5A5A;
    mem[16'h0001] = 16'hC3C3;
    run_scan(16'hFFFF, 16'd3, 0, 1'b0);

    // Reset while the fifth word is stalled, then a clean full scan
    reset_mid_scan();
    ready_rand = 1'b1;
    run_scan(16'h4000, 16'd3, 0, 1'b0);

    // Start pulses while busy and during FIN
    run_scan(16'h2000, 16'd4, 7, 1'b1);
    run_scan(16'h2100, 16'd1, 20, 1'b1);

    // Randomised scans
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
      pc = 16'($urandom);
      run_scan(16'($urandom_range(0, 1) == 1 ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                             : 16'($urandom)),
               16'($urandom_range(0, 12)), 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/punc_debug_scanner.md
Name: punc_debug_scanner

Overview:
- Reader-side master for the PUnC debug port.
- On a start pulse it snapshots processor state by sweeping the debug address inputs: PC, then R0–R7, then a memory window.
- Each sampled word goes out on a valid/ready stream toward a host-side logger or UART bridge.
- Sits beside the PUnC top and drives its mem_debug_addr/rf_debug_addr; it never disturbs execution.

Parameters:
- CNT_W, 16, width of the memory word-count input and internal counter.
- ADDR_W, 16, memory debug address width; addresses wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a scan; honoured only when idle
- mem_base  in  ADDR_W  first memory address of the window; latched on accepted start
- mem_count  in  CNT_W  number of memory words to dump; latched on accepted start; 0 means no memory words
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the final word's handshake
- dbg_mem_addr  out  ADDR_W  drives PUnC mem_debug_addr
- dbg_rf_addr  out  3  drives PUnC rf_debug_addr
- dbg_mem_data  in  16  from PUnC mem_debug_data
- dbg_rf_data  in  16  from PUnC rf_debug_data
- dbg_pc_data  in  16  from PUnC pc_debug_data
- out_valid  out  1  stream word valid
- out_ready  in  1  stream sink ready
- out_data  out  16  sampled word
- out_tag  out  2  word class: 0 = PC, 1 = register, 2 = memory, 3 = checksum
- out_last  out  1  marks the final word of a scan

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - all outputs go to 0; the FSM goes to IDLE; latched base/count clear.
  - Applies mid-scan too: any held word is discarded without handshake, and done does not pulse.
- FSM states: IDLE, ADDR, CAP, SEND, FIN.
- IDLE:
  - start = 1 latches mem_base and mem_count, sets busy, sets item index to PC, and goes to ADDR.
  - start in any other state is ignored.
- ADDR:
  - Drive the address for the current item: dbg_rf_addr = register index, dbg_mem_addr = base + offset (wraps).
  - For the PC item the addresses hold their previous values.
  - Next state is CAP.
- CAP:
  - Addresses unchanged.
  - At the end of CAP, sample the selected input (pc, rf, or mem) into out_data, set out_tag, and set out_last if this is the final item.
  - Set out_valid and go to SEND.
  - Addresses are therefore stable at least one full cycle before sampling, so the scanner works with combinational or 1-cycle-registered debug reads.
- SEND:
  - out_data, out_tag, and out_last stay stable while out_valid = 1 and out_ready = 0.
  - On out_valid & out_ready: clear out_valid.
    - If the word was last, go to FIN.
    - Otherwise advance the item and go to ADDR.
  - out_ready while out_valid = 0 has no effect.
- FIN: pulse done for one cycle, clear busy, return to IDLE. A start in this cycle is ignored.
- Item order: PC, R0..R7, then mem[base], mem[base+1], ..., mem[base+count-1].
  - Total words = 9 + count (plus 1 with the optional feature).
  - With count = 0, R7 carries out_last (unless the checksum is enabled).
  - The offset counter is CNT_W bits. count = 2^CNT_W−1 is legal; the address wraps past 0xFFFF to 0x0000.
- Throughput: at most one word every 3 cycles; each sink stall cycle adds exactly one cycle.
- Latency: accepted start at cycle t gives first out_valid at t+3.

Optional Feature:
- Macro: PUNC_DBG_CHECKSUM_EN.
- When defined:
  - a 16-bit running sum (mod 2^16) accumulates every emitted word, updated at handshake;
  - after the last regular word, one extra word is emitted with tag 3 and data = sum, and only this word carries out_last;
  - the sum clears on accepted start and on reset.
- When undefined: no accumulator; tag 3 is never produced; the final regular word carries out_last.

Decomposition:
- Shared package (punc_dbg_pkg) holds:
  - the state enum (IDLE, ADDR, CAP, SEND, FIN);
  - tag constants TAG_PC = 0, TAG_RF = 1, TAG_MEM = 2, TAG_CSUM = 3;
  - NUM_RF = 8.
- One natural sub-module: punc_dbg_outreg, the single-entry valid/ready holding register with the data, tag, and last fields.
- Item sequencing and address generation stay in the top.

Test Plan:
- Reset, then start with base = 0x3000, count = 2, out_ready held 1, PUnC loaded with PC = 0x3000, R0..R7 = 0x0010..0x0017, mem[0x3000] = 0xABCD, mem[0x3001] = 0x1234 -> exactly 11 words:
  - tags 0, 1×8, 2×2;
  - data 0x3000, 0x0010..0x0017, 0xABCD, 0x1234;
  - out_last only on 0x1234; done pulses once; busy low afterward.
- Same scan with out_ready toggled in a random pattern -> identical word sequence; out_data/out_tag/out_last never change while valid and not ready.
- count = 0 -> 9 words, out_last on R7. With PUNC_DBG_CHECKSUM_EN -> 10th word, tag 3, data = sum of the 9 words mod 2^16.
- base = 0xFFFF, count = 3 -> memory words read from 0xFFFF, 0x0000, 0x0001 in that order.
- Assert rst while the 5th word is stalled (out_ready = 0) -> next cycle: out_valid = 0, busy = 0, no done pulse. A new start then produces a full scan beginning with PC.
- start pulsed during busy and during FIN -> ignored: word count and order unchanged, no second scan.
